dice_roller_display: RTL

//  Multi-die roller and pip-pattern driver for the dice board. A roll request starts a timed
//  "tumbling" animation: die values are re-drawn from a free-running LFSR at a fixed tick rate.
//  The final values are then held and a done pulse is issued.

---
 rtl/dice_roller_display.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dice_roller_display.sv
// Dice roller: LFSR-driven tumbling animation, then hold and pulse done; registered pip decode per die.
// Optional per-die hold during a roll is enabled by defining DICE_HOLD_EN.
module dice_pip_decode (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [2:0] i_Value,
  output logic [6:0] o_Pips
);
  always_ff @(posedge i_Clk) begin
    if (i_Reset) o_Pips <= 7'b0000000;
    else begin
      case (i_Value)
        3'd1:    o_Pips <= 7'b0000001;
        3'd2:    o_Pips <= 7'b1000010;
        3'd3:    o_Pips <= 7'b1000011;
        3'd4:    o_Pips <= 7'b1100110;
        3'd5:    o_Pips <= 7'b1100111;
        3'd6:    o_Pips <= 7'b1111110;
        default: o_Pips <= 7'b0000000;
      endcase
    end
  end
endmodule

module dice_roller_display #(
  parameter int          NUM_DICE    = 2,
  parameter int          TICK_CYCLES = 2500000,
  parameter int          ROLL_TICKS  = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Roll,
  input  logic                    i_Load,
  input  logic [3*NUM_DICE-1:0]   i_Load_Values,
  input  logic [NUM_DICE-1:0]     i_Hold,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic [3*NUM_DICE-1:0]   o_Values,
  output logic [7*NUM_DICE-1:0]   o_Dice
);
  localparam int TCW = $clog2(TICK_CYCLES + 1);
  localparam int RCW = $clog2(ROLL_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ROLLING, S_DONE} state_t;

  state_t                     r_State;
  logic [15:0]                r_Lfsr;
  logic [TCW-1:0]             r_Tick_Cnt;
  logic [RCW-1:0]             r_Roll_Cnt;
  logic [NUM_DICE-1:0][2:0]   r_Values;
  logic                       r_Busy;
  logic                       r_Done;

  logic                       w_Feedback;
  logic                       w_Tick_Term;
  logic [NUM_DICE-1:0][2:0]   w_Draw;
  logic [NUM_DICE-1:0]        w_Held;
  logic [NUM_DICE-1:0]        w_Take;
  logic [NUM_DICE-1:0][6:0]   w_Pips;

  assign w_Feedback  = r_Lfsr[15] ^ r_Lfsr[13] ^ r_Lfsr[12] ^ r_Lfsr[10];
  assign w_Tick_Term = (r_Tick_Cnt == TCW'(TICK_CYCLES - 1));

`ifdef DICE_HOLD_EN
  assign w_Held = i_Hold;
`else
  logic w_unused_hold;
  assign w_unused_hold = ^i_Hold;
  assign w_Held = '0;
`endif

  // Each die draws its own 3-bit LFSR slice; 0 and 7 are rejected so the face keeps its value.
  for (genvar k = 0; k < NUM_DICE; k++) begin : g_die
    assign w_Draw[k] = r_Lfsr[3*k +: 3];
    assign w_Take[k] = (w_Draw[k] != 3'd0) && (w_Draw[k] != 3'd7) && !w_Held[k];
    dice_pip_decode u_pip (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Value (r_Values[k]),
      .o_Pips  (w_Pips[k])
    );
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State    <= S_IDLE;
      r_Lfsr     <= LFSR_SEED;
      r_Tick_Cnt <= '0;
      r_Roll_Cnt <= '0;
      r_Values   <= '0;
      r_Busy     <= 1'b0;
      r_Done     <= 1'b0;
    end else begin
      r_Lfsr <= {r_Lfsr[14:0], w_Feedback};
      r_Done <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (i_Roll) begin
            r_State    <= S_ROLLING;
            r_Busy     <= 1'b1;
            r_Tick_Cnt <= '0;
            r_Roll_Cnt <= '0;
          end else if (i_Load) begin
            r_Values <= i_Load_Values;
          end
        end
        S_ROLLING: begin
          if (w_Tick_Term) begin
            r_Tick_Cnt <= '0;
            for (int k = 0; k < NUM_DICE; k++)
              if (w_Take[k]) r_Values[k] <= w_Draw[k];
            if (r_Roll_Cnt == RCW'(ROLL_TICKS - 1)) begin
              r_State    <= S_DONE;
              r_Busy     <= 1'b0;
              r_Done     <= 1'b1;
              r_Roll_Cnt <= '0;
            end else begin
              r_Roll_Cnt <= r_Roll_Cnt + 1'b1;
            end
          end else begin
            r_Tick_Cnt <= r_Tick_Cnt + 1'b1;
          end
        end
        S_DONE:  r_State <= S_IDLE;
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Busy   = r_Busy;
  assign o_Done   = r_Done;
  assign o_Values = r_Values;
  assign o_Dice   = w_Pips;
endmodule
